// File: rtl/br_pkg.sv
// Shared encodings for branch resolution: opcodes, FSM states and the
// delay-slot length, plus the branch target helper.
package br_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BGEZ = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLEZ = 3'd4,
        BR_BLTZ = 3'd5
    } br_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        DSLOT     = 2'd2
    } br_state_e;

    localparam int unsigned DSLOT_LEN = 1;

    function automatic logic [31:0] br_target(
        input logic [31:0] pc4,
        input logic [15:0] imm
    );
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/br_cond.sv
// Combinational branch condition evaluator on signed 32-bit operands;
// also used by the EX-stage comparator.
module br_cond
    import br_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        taken,
    output logic        illegal
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = ~|rs;
    assign rs_neg  = rs[31];

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        unique case (op)
            BR_BEQ:  taken = (rs == rt);
            BR_BNE:  taken = (rs != rt);
            BR_BGEZ: taken = ~rs_neg;
            BR_BGTZ: taken = ~rs_neg & ~rs_zero;
            BR_BLEZ: taken = rs_neg | rs_zero;
            BR_BLTZ: taken = rs_neg;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolver: operand-wait stall, condition and target,
// delay-slot timed PC redirect, sticky error and saturating statistics.
module branch_resolver
    import br_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [2:0]       br_op,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             opnd_ready,
    input  logic [31:0]      pc4,
    input  logic [15:0]      imm16,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             ds_active,
    output logic             br_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int DS_W = (DSLOT_LEN > 1) ? $clog2(DSLOT_LEN) : 1;

    br_state_e         state_q, state_d;
    logic [DS_W-1:0]   ds_cnt_q;
    logic              ds_done;
    logic              in_dslot;
    logic              resolve;
    logic              ds_branch;
    logic              taken;
    logic              illegal;
    logic [31:0]       target;

    logic              redirect_valid_q;
    logic [31:0]       redirect_pc_q;
    logic              br_err_q;
    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  taken_cnt_q;

    br_cond u_cond (
        .op      (br_op),
        .rs      (rs_val),
        .rt      (rt_val),
        .taken   (taken),
        .illegal (illegal)
    );

    assign target  = br_target(pc4, imm16);
    assign ds_done = (ds_cnt_q == DS_W'(DSLOT_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, WAIT_OPND: begin
                if (!br_valid) begin
                    state_d = IDLE;
                end else if (opnd_ready) begin
                    state_d = DSLOT;
                end else begin
                    state_d = WAIT_OPND;
                end
            end
            DSLOT: begin
                if (ds_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_dslot  = (state_q == DSLOT);
        resolve   = br_valid & opnd_ready & ~in_dslot;
        stall_id  = br_valid & ~opnd_ready & ~in_dslot;
        ds_branch = br_valid & in_dslot;
        ds_active = in_dslot;
    end

    // Redirect PC only moves on a taken branch; not-taken keeps the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_cnt_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_err_q         <= 1'b0;
            branch_cnt_q     <= '0;
            taken_cnt_q      <= '0;
        end else begin
            ds_cnt_q         <= in_dslot ? ds_cnt_q + DS_W'(1) : '0;
            redirect_valid_q <= resolve & taken;
            if (resolve & taken) begin
                redirect_pc_q <= target;
            end
            if ((resolve & illegal) | ds_branch) begin
                br_err_q <= 1'b1;
            end
            if (resolve & ~&branch_cnt_q) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            end
            if (resolve & taken & ~&taken_cnt_q) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign br_err         = br_err_q;
    assign branch_cnt     = branch_cnt_q;
    assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed cases plus random stimulus
// against a cycle-level reference model of the branch rules.
module tb_branch_resolver;

    localparam int unsigned CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_valid = 1'b0;
    logic [2:0]    br_op = 3'd0;
    logic [31:0]   rs_val = '0;
    logic [31:0]   rt_val = '0;
    logic          opnd_ready = 1'b0;
    logic [31:0]   pc4 = '0;
    logic [15:0]   imm16 = '0;
    logic          stall_id;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          ds_active;
    logic          br_err;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] taken_cnt;

    branch_resolver #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .br_op          (br_op),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .opnd_ready     (opnd_ready),
        .pc4            (pc4),
        .imm16          (imm16),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ds_active      (ds_active),
        .br_err         (br_err),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit          m_dslot;
    bit          m_rv;
    bit          m_err;
    logic [31:0] m_pc;
    int          m_bc;
    int          m_tc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input int op, input int a, input int b);
        case (op)
            0: return a == b;
            1: return a != b;
            2: return a >= 0;
            3: return a > 0;
            4: return a <= 0;
            5: return a < 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_regs();
        check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        check("redirect_pc", redirect_pc, m_pc);
        check("ds_active", 32'(ds_active), 32'(m_dslot));
        check("br_err", 32'(br_err), 32'(m_err));
        check("branch_cnt", 32'(branch_cnt), 32'(m_bc));
        check("taken_cnt", 32'(taken_cnt), 32'(m_tc));
    endtask

    task automatic step();
        bit res;
        bit tk;
        #1;
        check("stall_id", 32'(stall_id),
              32'(br_valid && !opnd_ready && !m_dslot));
        res = br_valid && opnd_ready && !m_dslot;
        tk  = res && ref_taken(int'(br_op), int'(rs_val), int'(rt_val));
        @(posedge clk);
        #1;
        if (br_valid && m_dslot) m_err = 1'b1;
        if (res && br_op > 3'd5) m_err = 1'b1;
        if (res && m_bc < CNT_MAX) m_bc++;
        if (tk && m_tc < CNT_MAX) m_tc++;
        if (tk) m_pc = pc4 + 32'(int'($signed(imm16)) * 4);
        m_rv    = tk;
        m_dslot = res;
        check_regs();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        br_valid   = 1'b0;
        opnd_ready = 1'b0;
        #1;
        m_dslot = 1'b0;
        m_rv    = 1'b0;
        m_err   = 1'b0;
        m_pc    = '0;
        m_bc    = 0;
        m_tc    = 0;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic rdy,
                          input logic [31:0] p, input logic [15:0] im);
        br_valid   = 1'b1;
        br_op      = op;
        rs_val     = rs;
        rt_val     = rt;
        opnd_ready = rdy;
        pc4        = p;
        imm16      = im;
    endtask

    task automatic idle();
        br_valid   = 1'b0;
        opnd_ready = 1'b0;
        step();
    endtask

    initial begin
        do_reset();

        set_br(3'd2, 32'h0, 32'h0, 1'b1, 32'h00400004, 16'h0003);
        step();
        check("bgez_rv", 32'(redirect_valid), 32'd1);
        check("bgez_pc", redirect_pc, 32'h00400010);
        check("bgez_ds", 32'(ds_active), 32'd1);
        check("bgez_bc", 32'(branch_cnt), 32'd1);
        check("bgez_tc", 32'(taken_cnt), 32'd1);
        idle();

        set_br(3'd5, 32'h7FFFFFFF, 32'h0, 1'b1, 32'h00400020, 16'h0010);
        step();
        check("bltz_rv", 32'(redirect_valid), 32'd0);
        check("bltz_ds", 32'(ds_active), 32'd1);
        check("bltz_tc", 32'(taken_cnt), 32'd1);
        check("bltz_pc_hold", redirect_pc, 32'h00400010);
        idle();

        for (int i = 0; i < 3; i++) begin
            set_br(3'd0, 32'd5, 32'd5, 1'b0, 32'h00001000, 16'h0004);
            #1;
            check("beq_stall", 32'(stall_id), 32'd1);
            step();
            check("beq_wait_rv", 32'(redirect_valid), 32'd0);
        end
        opnd_ready = 1'b1;
        step();
        check("beq_rv", 32'(redirect_valid), 32'd1);
        check("beq_pc", redirect_pc, 32'h00001010);
        check("beq_bc", 32'(branch_cnt), 32'd3);

        idle();
        set_br(3'd1, 32'd1, 32'd2, 1'b1, 32'h00010000, 16'h8000);
        step();
        check("bne_wrap_pc", redirect_pc, 32'hFFFF0000);

        set_br(3'd0, 32'd7, 32'd7, 1'b1, 32'h00002000, 16'h0001);
        step();
        check("ds_br_rv", 32'(redirect_valid), 32'd0);
        check("ds_br_err", 32'(br_err), 32'd1);
        check("ds_br_bc", 32'(branch_cnt), 32'd4);
        idle();
        idle();
        check("err_sticky", 32'(br_err), 32'd1);

        set_br(3'd0, 32'd1, 32'd1, 1'b0, 32'h00003000, 16'h0002);
        step();
        idle();
        check("flush_rv", 32'(redirect_valid), 32'd0);
        check("flush_bc", 32'(branch_cnt), 32'd4);
        idle();

        do_reset();
        check("rst_err", 32'(br_err), 32'd0);
        set_br(3'd6, 32'd0, 32'd0, 1'b1, 32'h00004000, 16'h0002);
        step();
        check("rsv_err", 32'(br_err), 32'd1);
        check("rsv_rv", 32'(redirect_valid), 32'd0);
        check("rsv_bc", 32'(branch_cnt), 32'd1);
        idle();

        set_br(3'd0, 32'd3, 32'd3, 1'b0, 32'h00005000, 16'h0002);
        step();
        do_reset();
        set_br(3'd3, 32'd9, 32'd0, 1'b1, 32'h00006000, 16'h0002);
        step();
        check("pre_rst_rv", 32'(redirect_valid), 32'd1);
        do_reset();
        check("mid_ds_rst_rv", 32'(redirect_valid), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rs;
            if ($urandom_range(0, 199) == 0) do_reset();
            case ($urandom_range(0, 5))
                0: rs = 32'h0;
                1: rs = 32'h1;
                2: rs = 32'hFFFFFFFF;
                3: rs = 32'h7FFFFFFF;
                4: rs = 32'h80000000;
                default: rs = $urandom;
            endcase
            br_valid   = ($urandom_range(0, 3) != 0);
            br_op      = ($urandom_range(0, 15) == 0) ?
                         3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            rs_val     = rs;
            rt_val     = ($urandom_range(0, 1) != 0) ? rs : $urandom;
            opnd_ready = ($urandom_range(0, 2) != 0);
            pc4        = $urandom & 32'hFFFFFFFC;
            imm16      = 16'($urandom);
            step();
        end

        do_reset();
        for (int i = 0; i < 300; i++) begin
            set_br(3'd0, 32'd9, 32'd9, 1'b1, 32'h00007000, 16'h0001);
            step();
            idle();
        end
        check("sat_bc", 32'(branch_cnt), 32'd255);
        check("sat_tc", 32'(taken_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Sequential branch-resolution unit for the ID stage of the pipelined MIPS core. It consumes decoded branch instructions and their forwarded operands, and stalls ID until the operands are final. It then evaluates the branch condition (BEQ/BNE/BGEZ/BGTZ/BLEZ/BLTZ), computes the target and issues a one-cycle PC redirect timed to the architectural delay slot. It also keeps saturating branch statistics for the debug readout.

## Interface
Parameters:
- CNT_W, 16, width of statistics counters

Ports (clock and reset first). Clock is one clock `clk`. Reset is asynchronous, active-low `rst_n`.
- clk  in  1  single core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  ID holds a branch instruction
- br_op  in  3  0 BEQ, 1 BNE, 2 BGEZ, 3 BGTZ, 4 BLEZ, 5 BLTZ, 6–7 reserved
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand (BEQ/BNE only)
- opnd_ready  in  1  forwarding unit reports rs/rt final this cycle
- pc4  in  32  PC+4 of the branch
- imm16  in  16  branch offset field
- stall_id  out  1  hold IF/ID (combinational)
- redirect_valid  out  1  one-cycle pulse, load redirect_pc into PC
- redirect_pc  out  32  branch target
- ds_active  out  1  delay-slot instruction is in ID
- br_err  out  1  sticky: reserved op, or branch in delay slot
- branch_cnt  out  CNT_W  resolved branches, saturating
- taken_cnt  out  CNT_W  taken branches, saturating

## Operation
- States: IDLE, WAIT_OPND, DSLOT.
- IDLE:
  - br_valid & opnd_ready: resolve this cycle and go to DSLOT.
  - br_valid & !opnd_ready: go to WAIT_OPND.
- WAIT_OPND:
  - opnd_ready & br_valid: resolve and go to DSLOT.
  - !br_valid (pipeline flush): go to IDLE with no count and no redirect.
- DSLOT: lasts exactly one cycle, then returns to IDLE.
  - br_valid in DSLOT is ignored and sets br_err. It does not resolve, count or stall.
- stall_id = br_valid & !opnd_ready & (state is IDLE or WAIT_OPND).
- Resolve:
  - Evaluate the condition on signed 32-bit values.
  - BGEZ: rs ≥ 0. BGTZ: rs > 0. BLEZ: rs ≤ 0. BLTZ: rs < 0.
  - BEQ/BNE compare rs with rt.
  - Reserved op: not taken, sets br_err, still counted.
- Target = pc4 + (sign_extend(imm16) << 2), modulo 2^32. Wrap-around is silent.
- Counters: on resolve, branch_cnt += 1; if taken, taken_cnt += 1. Both hold at all-ones.
- br_err is cleared only by reset.

## Timing
- Reset: state IDLE; redirect_valid 0; redirect_pc 0; ds_active 0; br_err 0; both counters 0.
- All outputs except stall_id are registered.
- Branch resolved at edge T:
  - ds_active = 1 during cycle T+1.
  - redirect_valid = taken during cycle T+1, with redirect_pc valid in the same cycle. Fetch at T+2 uses the target.
- Not-taken branch: redirect_valid stays 0 and redirect_pc holds its previous value.
- Back-to-back branches: minimum spacing is 2 cycles (branch, delay slot).
- Reset asserted mid-WAIT_OPND or mid-DSLOT: immediate return to reset values. A pending redirect is discarded.
- opnd_ready and br_valid both rising in the same cycle in IDLE: resolve with no stall cycle (zero-stall case).

## Structure
- Package `br_pkg` holds:
  - br_op encodings (BR_BEQ..BR_BLTZ)
  - state enum
  - DSLOT length constant (1)
- Sub-module `br_cond`: purely combinational.
  - Inputs: op, rs, rt. Outputs: taken, illegal.
  - Reusable by the EX-stage comparator.
- Top module holds the FSM, the target adder, the output registers and the counters.

## Test plan
- Reset, then BGEZ with rs=0x00000000, opnd_ready=1, pc4=0x00400004, imm16=0x0003 → at T+1 redirect_valid=1, redirect_pc=0x00400010, ds_active=1; branch_cnt=1, taken_cnt=1.
- BLTZ with rs=0x7FFFFFFF → not taken: redirect_valid=0, ds_active=1; taken_cnt unchanged.
- BEQ with rs=rt=5, opnd_ready low for 3 cycles → stall_id=1 for those 3 cycles; redirect at the cycle after opnd_ready rises; exactly one count.
- BNE with imm16=0x8000, pc4=0x00010000 → redirect_pc=0xFFFF0000 (negative offset wraps).
- Branch in delay slot, or br_op=6 → br_err=1 and sticky until reset; delay-slot branch gives no redirect.
- br_valid dropped while in WAIT_OPND → IDLE, no redirect, counters unchanged. Also: force branch_cnt to 0xFFFF and resolve → count stays at 0xFFFF.
